// File: rtl/val_rdy_queue_pkg.sv
// val_rdy_queue_pkg
//   Shared sizing helpers for the val/rdy queue. It holds the default
//   message width and depth, the pointer and count widths for that default
//   depth, and a clog2 constant function. Other files use the function to
//   size their own logic from their actual parameters.
//   No ports.
package val_rdy_queue_pkg;

  // Constant-evaluable ceil(log2(value)). Valid for value >= 1.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int DEF_NBITS       = 32;
  localparam int DEF_NUM_ENTRIES = 4;

  // Pointer width indexes the storage. Count width has to hold the value
  // "depth" itself, so it is sized for depth+1.
  localparam int DEF_PTR_W = clog2(DEF_NUM_ENTRIES);
  localparam int DEF_CNT_W = clog2(DEF_NUM_ENTRIES + 1);

endpackage

// File: rtl/val_rdy_queue_if.sv
// val_rdy_queue_if
//   Bundles the enqueue side, the dequeue side and the occupancy output of
//   the val/rdy queue.
//
//   Handshake: a side transfers a message on a rising clock edge if and
//   only if val and rdy are both 1 at that edge. A producer may raise val
//   without waiting for rdy. enq_rdy never depends on deq_rdy.
//
//   Signals
//     enq_val / enq_rdy / enq_msg : upstream producer side
//     deq_val / deq_rdy / deq_msg : downstream consumer side
//     num_free                    : free entry count
//   Modports
//     slave  : the queue itself
//     master : the environment that drives enq and consumes deq
interface val_rdy_queue_if
  import val_rdy_queue_pkg::*;
#(
  parameter int p_nbits       = DEF_NBITS,
  parameter int p_num_entries = DEF_NUM_ENTRIES
);
  localparam int CW = clog2(p_num_entries + 1);

  logic               enq_val;
  logic               enq_rdy;
  logic [p_nbits-1:0] enq_msg;
  logic               deq_val;
  logic               deq_rdy;
  logic [p_nbits-1:0] deq_msg;
  logic [CW-1:0]      num_free;

  modport slave (
    input  enq_val, enq_msg, deq_rdy,
    output enq_rdy, deq_val, deq_msg, num_free
  );

  modport master (
    output enq_val, enq_msg, deq_rdy,
    input  enq_rdy, deq_val, deq_msg, num_free
  );

endinterface

// File: rtl/val_rdy_queue_ctrl.sv
// val_rdy_queue_ctrl
//   Queue control. Holds the write pointer, the read pointer and the
//   occupancy count. It produces the handshake ready/valid signals and the
//   write/advance strobes for the storage held in the top level.
//   Optional macro VAL_RDY_QUEUE_BYPASS_EN adds a zero-cycle path from enq
//   to deq when the queue is empty.
//   Ports
//     clk, reset     : clock; synchronous active-low reset
//     enq_val        : upstream valid
//     deq_rdy        : downstream ready
//     enq_rdy        : count != depth
//     deq_val        : count != 0 (or a bypassing message)
//     num_free       : depth - count
//     wr_ptr, rd_ptr : storage write/read indices
//     wr_en          : write enq_msg to storage[wr_ptr] this edge
//     bypass_sel     : deq_msg should come straight from enq_msg
module val_rdy_queue_ctrl
  import val_rdy_queue_pkg::*;
#(
  parameter int p_num_entries = DEF_NUM_ENTRIES,
  localparam int PW = clog2(p_num_entries),
  localparam int CW = clog2(p_num_entries + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enq_val,
  input  logic          deq_rdy,
  output logic          enq_rdy,
  output logic          deq_val,
  output logic [CW-1:0] num_free,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic          wr_en,
  output logic          bypass_sel
);

  logic [CW-1:0] count;
  logic          enq_go;
  logic          deq_go;
  logic          rd_adv;

  assign enq_rdy  = (count != CW'(p_num_entries));
  assign num_free = CW'(p_num_entries) - count;
  assign enq_go   = enq_val && enq_rdy;

`ifdef VAL_RDY_QUEUE_BYPASS_EN
  logic bypass_go;
  // When the queue is empty, an arriving message is presented on deq
  // immediately. If it is also taken in the same cycle, it never touches
  // storage, so the pointers and the count must stay put.
  assign bypass_sel = (count == '0) && enq_val;
  assign deq_val    = (count != '0) || bypass_sel;
  assign deq_go     = deq_val && deq_rdy;
  assign bypass_go  = bypass_sel && deq_rdy;
  assign wr_en      = enq_go && !bypass_go;
  assign rd_adv     = deq_go && !bypass_go;
`else
  assign bypass_sel = 1'b0;
  assign deq_val    = (count != '0);
  assign deq_go     = deq_val && deq_rdy;
  assign wr_en      = enq_go;
  assign rd_adv     = deq_go;
`endif

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + PW'(1);
      if (rd_adv) rd_ptr <= rd_ptr + PW'(1);
      if (wr_en && !rd_adv)      count <= count + CW'(1);
      else if (!wr_en && rd_adv) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/val_rdy_queue.sv
// val_rdy_queue
//   Parameterised val/rdy FIFO with circular-buffer storage. It absorbs rate
//   mismatch and backpressure between a producer and a downstream pipeline
//   register. Control lives in val_rdy_queue_ctrl. This level holds the
//   storage array and the read mux.
//   Optional macro VAL_RDY_QUEUE_BYPASS_EN: zero-cycle enq->deq pass-through
//   when empty. Without it, every output is driven only from registered
//   state.
//   Ports
//     clk   : clock; all state updates on posedge
//     reset : synchronous, active-low
//     q     : val_rdy_queue_if.slave (enq side, deq side, num_free)
//   Parameters
//     p_nbits       : message width (>= 1)
//     p_num_entries : depth, power of two, >= 2
module val_rdy_queue
  import val_rdy_queue_pkg::*;
#(
  parameter int p_nbits       = DEF_NBITS,
  parameter int p_num_entries = DEF_NUM_ENTRIES
) (
  input  logic           clk,
  input  logic           reset,
  val_rdy_queue_if.slave q
);

  localparam int PW = clog2(p_num_entries);

  logic [p_nbits-1:0] storage [p_num_entries];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic               wr_en;
  logic               bypass_sel;

  val_rdy_queue_ctrl #(
    .p_num_entries (p_num_entries)
  ) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .enq_val    (q.enq_val),
    .deq_rdy    (q.deq_rdy),
    .enq_rdy    (q.enq_rdy),
    .deq_val    (q.deq_val),
    .num_free   (q.num_free),
    .wr_ptr     (wr_ptr),
    .rd_ptr     (rd_ptr),
    .wr_en      (wr_en),
    .bypass_sel (bypass_sel)
  );

  // Storage is deliberately not reset. A write during a reset cycle is
  // suppressed so a discarded message cannot land in the array.
  always_ff @(posedge clk) begin
    if (reset && wr_en) storage[wr_ptr] <= q.enq_msg;
  end

  assign q.deq_msg = bypass_sel ? q.enq_msg : storage[rd_ptr];

endmodule

// File: tb/tb_val_rdy_queue.sv
module tb_val_rdy_queue;

  localparam int NB = 8;
  localparam int NE = 4;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  val_rdy_queue_if #(.p_nbits(NB), .p_num_entries(NE)) q ();

  val_rdy_queue #(
    .p_nbits       (NB),
    .p_num_entries (NE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .q     (q)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Move past the next rising edge so that outputs are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply the inputs and let the combinational outputs settle.
  task automatic drive(input logic ev, input logic [NB-1:0] em, input logic dr);
    q.enq_val = ev;
    q.enq_msg = em;
    q.deq_rdy = dr;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    drive(1'b0, '0, 1'b0);

    // 1: reset held low for two edges
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rst_enq_rdy", 32'(q.enq_rdy), 32'd1);
    chk("rst_deq_val", 32'(q.deq_val), 32'd0);
    chk("rst_num_free", 32'(q.num_free), 32'd4);

    // 2: fill with A0..A3 while deq is blocked
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, NB'(8'hA0 + i), 1'b0);
      chk("fill_num_free", 32'(q.num_free), 32'(4 - i));
      tick();
    end
    drive(1'b1, 8'hAF, 1'b0);
    chk("full_enq_rdy", 32'(q.enq_rdy), 32'd0);
    chk("full_num_free", 32'(q.num_free), 32'd0);
    chk("full_deq_val", 32'(q.deq_val), 32'd1);
    tick();
    chk("fifth_ignored", 32'(q.num_free), 32'd0);
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("drain_val", 32'(q.deq_val), 32'd1);
      chk("drain_msg", 32'(q.deq_msg), 32'(8'hA0 + i));
      tick();
    end
    chk("drained_val", 32'(q.deq_val), 32'd0);
    chk("drained_free", 32'(q.num_free), 32'd4);

    // 3: two queued, then ten cycles of simultaneous enq and deq
    drive(1'b1, 8'hB0, 1'b0);
    tick();
    drive(1'b1, 8'hB1, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, NB'(8'hB2 + i), 1'b1);
      chk("sim_msg", 32'(q.deq_msg), 32'(8'hB0 + i));
      chk("sim_free", 32'(q.num_free), 32'd2);
      tick();
    end
    drive(1'b0, '0, 1'b1);
    chk("sim_tail0", 32'(q.deq_msg), 32'hBA);
    tick();
    chk("sim_tail1", 32'(q.deq_msg), 32'hBB);
    tick();
    chk("sim_empty", 32'(q.deq_val), 32'd0);

    // 4: full, with deq_rdy=1 in the same cycle; the enq must be refused
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, NB'(8'hC0 + i), 1'b0);
      tick();
    end
    drive(1'b1, 8'hC4, 1'b1);
    chk("fulldeq_enq_rdy", 32'(q.enq_rdy), 32'd0);
    chk("fulldeq_msg", 32'(q.deq_msg), 32'hC0);
    tick();
    drive(1'b0, '0, 1'b0);
    chk("fulldeq_enq_rdy_next", 32'(q.enq_rdy), 32'd1);
    chk("fulldeq_free", 32'(q.num_free), 32'd1);
    chk("fulldeq_head", 32'(q.deq_msg), 32'hC1);

    // 5: reset with three queued; traffic offered during reset is discarded
    reset = 1'b0;
    drive(1'b1, 8'hD0, 1'b1);
    tick();
    reset = 1'b1;
    drive(1'b0, '0, 1'b0);
    chk("midrst_deq_val", 32'(q.deq_val), 32'd0);
    chk("midrst_free", 32'(q.num_free), 32'd4);
    chk("midrst_enq_rdy", 32'(q.enq_rdy), 32'd1);
    drive(1'b1, 8'hE0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b1);
    chk("post_rst_head", 32'(q.deq_msg), 32'hE0);
    tick();
    chk("post_rst_empty", 32'(q.deq_val), 32'd0);

    // 6: empty queue, enq_val and deq_rdy together
    drive(1'b1, 8'h55, 1'b1);
`ifdef VAL_RDY_QUEUE_BYPASS_EN
    chk("byp_deq_val", 32'(q.deq_val), 32'd1);
    chk("byp_deq_msg", 32'(q.deq_msg), 32'h55);
    tick();
    drive(1'b0, '0, 1'b0);
    chk("byp_free", 32'(q.num_free), 32'd4);
    chk("byp_empty", 32'(q.deq_val), 32'd0);
`else
    chk("nobyp_deq_val", 32'(q.deq_val), 32'd0);
    tick();
    drive(1'b0, '0, 1'b0);
    chk("nobyp_late_val", 32'(q.deq_val), 32'd1);
    chk("nobyp_late_msg", 32'(q.deq_msg), 32'h55);
    chk("nobyp_free", 32'(q.num_free), 32'd3);
    drive(1'b0, '0, 1'b1);
    tick();
    chk("nobyp_empty", 32'(q.deq_val), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
